// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: redirect/stall control from later stages, instruction memory port and IF/ID outputs.
interface instruction_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        halted;
  logic        fetch_fault;

  modport master (
    input  stall, redirect, redirect_target, imem_data,
    output imem_address, id_valid, id_pc, id_instr, halted, fetch_fault
  );

  modport slave (
    output stall, redirect, redirect_target, imem_data,
    input  imem_address, id_valid, id_pc, id_instr, halted, fetch_fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC generation and IF/ID register in front of a synchronous-read instruction memory.
// Handles stall, redirect flush, PC wrap, halt detection and bad-target fault.
module instruction_fetch_unit #(
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned DEPTH      = 10,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] PC_RST  = AW'(RESET_PC);
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PC_LIM  = AW'(DEPTH);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          id_valid_q, id_valid_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic [31:0]   id_instr_q, id_instr_d;
  logic          fault_q, fault_d;

  // State register: sync reset clears everything, discarding in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= PC_RST;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state, next-PC and IF/ID update; redirect outranks stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    fault_d    = fault_q;
    case (state_q)
      S_BOOT: begin
        // Memory output is still the reset zero; wait one cycle for alignment.
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.redirect) begin
          id_valid_d = 1'b0;
          if (bus.redirect_target < PC_LIM) begin
            pc_d = bus.redirect_target;
          end else begin
            fault_d = 1'b1;
            state_d = S_HALTED;
          end
        end else if (!bus.stall) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc_q;
          id_instr_d = bus.imem_data;
          pc_d       = (pc_q == PC_LAST) ? '0 : pc_q + AW'(1);
          if (bus.imem_data == HALT_INSTR) begin
            state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        // A stalled decode keeps seeing the HALT word.
        if (!bus.stall) begin
          id_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign bus.imem_address = rst ? PC_RST : pc_d;
  assign bus.id_valid     = id_valid_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_instr     = id_instr_q;
  assign bus.halted       = (state_q == S_HALTED);
  assign bus.fetch_fault  = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// against a word-level fetch model driving a synchronous-read memory.
module tb_instruction_fetch_unit;
  localparam int unsigned DEPTH    = 10;
  localparam int unsigned RESET_PC = 0;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .HALT_INSTR(HALT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:DEPTH-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory, zero while rst is high.
  always @(posedge clk) begin
    if (rst) bus.imem_data <= 32'd0;
    else if (bus.imem_address < DEPTH) bus.imem_data <= mem[bus.imem_address];
    else bus.imem_data <= 32'd0;
  end

  int npass = 0;
  int ntotal = 0;

  // Reference model: next word to deliver, warm-up edges, and expected ID contents.
  int unsigned f_ptr;
  int          warm;
  logic        m_valid, m_halted, m_fault;
  logic [31:0] m_pc, m_instr;
  logic [31:0] addr_seen, addr_exp;

  function automatic logic [66:0] obs();
    return {bus.id_valid, bus.id_pc, bus.id_instr, bus.halted, bus.fetch_fault};
  endfunction

  function automatic logic [66:0] expv();
    return {m_valid, m_pc, m_instr, m_halted, m_fault};
  endfunction

  task automatic model_reset();
    f_ptr = RESET_PC; warm = 1;
    m_valid = 0; m_pc = 0; m_instr = 0; m_halted = 0; m_fault = 0;
  endtask

  function automatic logic [31:0] model_addr(input logic s, input logic r, input logic [31:0] t,
                                             input logic rs);
    if (rs) return 32'(RESET_PC);
    if (warm > 0 || m_halted) return 32'(f_ptr);
    if (r) return (t < DEPTH) ? t : 32'(f_ptr);
    if (s) return 32'(f_ptr);
    return 32'((f_ptr + 1) % DEPTH);
  endfunction

  task automatic model_edge(input logic s, input logic r, input logic [31:0] t, input logic rs);
    if (rs) model_reset();
    else if (warm > 0) warm--;
    else if (m_halted) begin
      if (!s) m_valid = 0;
    end else if (r) begin
      m_valid = 0;
      if (t < DEPTH) f_ptr = t;
      else begin m_fault = 1; m_halted = 1; end
    end else if (!s) begin
      m_valid = 1; m_pc = 32'(f_ptr); m_instr = mem[f_ptr];
      f_ptr = (f_ptr + 1) % DEPTH;
      if (m_instr == HALT) m_halted = 1;
    end
  endtask

  // One clock: drive at negedge, capture address before the edge, settle after it.
  task automatic step(input logic s, input logic r, input logic [31:0] t, input logic rs);
    @(negedge clk);
    rst = rs; bus.stall = s; bus.redirect = r; bus.redirect_target = t;
    #1;
    addr_seen = bus.imem_address;
    addr_exp  = model_addr(s, r, t, rs);
    @(posedge clk);
    model_edge(s, r, t, rs);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + 32'(i);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  // Unstalled stepping until the model shows word p in ID (bounded).
  task automatic run_until(input int unsigned p);
    int n = 0;
    while (!(m_valid && m_pc == p) && n < 40) begin
      step(0, 0, 0, 0);
      n++;
    end
    ntotal++;
    if (!(m_valid && m_pc == p)) $display("FAIL run_until: pc %0d not reached in 40 cycles", p);
    else npass++;
  endtask

  task automatic test_reset();
    init_mem();
    do_reset();
    ntotal++;
    if (addr_seen !== 32'(RESET_PC)) $display("FAIL reset_addr: got %0d exp %0d", addr_seen, RESET_PC);
    else npass++;
    ntotal++;
    if (obs() !== 67'd0) $display("FAIL reset_state: got %h exp 0", obs());
    else npass++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      ntotal++;
      if (obs() !== expv()) $display("FAIL seq_id[%0d]: got %h exp %h", i, obs(), expv());
      else npass++;
      ntotal++;
      if (addr_seen !== addr_exp) $display("FAIL seq_addr[%0d]: got %0d exp %0d", i, addr_seen, addr_exp);
      else npass++;
      if (i == 1) begin
        ntotal++;
        if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 32'd0, 32'h100})
          $display("FAIL first_word: got v%0b pc%0d %h exp v1 pc0 100", bus.id_valid, bus.id_pc, bus.id_instr);
        else npass++;
      end
    end
  endtask

  task automatic test_stall();
    run_until(4);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      ntotal++;
      if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 32'd4, 32'h104} || addr_seen !== 32'd5)
        $display("FAIL stall_hold[%0d]: got pc%0d %h addr%0d exp pc4 104 addr5", i, bus.id_pc, bus.id_instr, addr_seen);
      else npass++;
    end
    step(0, 0, 0, 0);
    ntotal++;
    if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 32'd5, 32'h105})
      $display("FAIL stall_release: got pc%0d %h exp pc5 105", bus.id_pc, bus.id_instr);
    else npass++;
  endtask

  task automatic test_redirect();
    for (int k = 0; k < 2; k++) begin
      run_until(6);
      step(k == 1, 1, 32'd2, 0);
      ntotal++;
      if (bus.id_valid !== 1'b0 || addr_seen !== 32'd2)
        $display("FAIL redirect_flush[%0d]: got v%0b addr%0d exp v0 addr2", k, bus.id_valid, addr_seen);
      else npass++;
      step(0, 0, 0, 0);
      ntotal++;
      if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 32'd2, 32'h102})
        $display("FAIL redirect_target[%0d]: got v%0b pc%0d %h exp v1 pc2 102", k, bus.id_valid, bus.id_pc, bus.id_instr);
      else npass++;
    end
  endtask

  task automatic test_wrap();
    run_until(9);
    step(0, 0, 0, 0);
    ntotal++;
    if ({bus.id_valid, bus.id_pc, bus.id_instr, bus.fetch_fault} !== {1'b1, 32'd0, 32'h100, 1'b0})
      $display("FAIL wrap: got pc%0d %h fault%0b exp pc0 100 fault0", bus.id_pc, bus.id_instr, bus.fetch_fault);
    else npass++;
  endtask

  task automatic test_halt();
    init_mem();
    mem[3] = HALT;
    do_reset();
    run_until(3);
    ntotal++;
    if ({bus.id_valid, bus.id_instr, bus.halted} !== {1'b1, HALT, 1'b1})
      $display("FAIL halt_seen: got v%0b %h h%0b exp v1 ffffffff h1", bus.id_valid, bus.id_instr, bus.halted);
    else npass++;
    step(0, 0, 0, 0);
    ntotal++;
    if (bus.id_valid !== 1'b0 || addr_seen !== 32'd4)
      $display("FAIL halt_drain: got v%0b addr%0d exp v0 addr4", bus.id_valid, addr_seen);
    else npass++;
    step(0, 1, 32'd7, 0);
    ntotal++;
    if (addr_seen !== 32'd4 || bus.halted !== 1'b1 || bus.id_valid !== 1'b0)
      $display("FAIL halt_redirect: got addr%0d h%0b v%0b exp addr4 h1 v0", addr_seen, bus.halted, bus.id_valid);
    else npass++;
    init_mem();
    do_reset();
    run_until(0);
    ntotal++;
    if ({bus.halted, bus.id_instr} !== {1'b0, 32'h100})
      $display("FAIL halt_restart: got h%0b %h exp h0 100", bus.halted, bus.id_instr);
    else npass++;
  endtask

  task automatic test_fault();
    run_until(5);
    step(0, 1, 32'd12, 0);
    for (int i = 0; i < 3; i++) begin
      ntotal++;
      if ({bus.fetch_fault, bus.halted, bus.id_valid} !== 3'b110 || addr_seen !== 32'd6)
        $display("FAIL fault[%0d]: got f%0b h%0b v%0b addr%0d exp f1 h1 v0 addr6",
                 i, bus.fetch_fault, bus.halted, bus.id_valid, addr_seen);
      else npass++;
      step(0, 0, 0, 0);
    end
    do_reset();
    ntotal++;
    if ({bus.fetch_fault, bus.halted} !== 2'b00)
      $display("FAIL fault_clear: got f%0b h%0b exp f0 h0", bus.fetch_fault, bus.halted);
    else npass++;
  endtask

  task automatic test_random();
    logic s, r, rs;
    logic [31:0] t;
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      rs = (m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0;
      if (rs)
        for (int j = 0; j < DEPTH; j++)
          mem[j] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 29) == 0) ? 32'(DEPTH) + 32'($urandom_range(0, 5))
                                       : 32'($urandom_range(0, DEPTH - 1));
      step(s, r, t, rs);
      ntotal++;
      if (obs() !== expv() || addr_seen !== addr_exp) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got %h addr%0d exp %h addr%0d", i, obs(), addr_seen, expv(), addr_exp);
        errs++;
      end else npass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'd0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_fault();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
